// File: rtl/pfir.sv
// pfir: N-tap pipelined FIR with shadow/active coefficient banks and valid/ready flow control.
// Optional PFIR_SAT_EN saturates the output instead of wrapping to OW bits.
module pfir #(
  parameter int N     = 8,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int OW    = 16,
  parameter int SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic signed [OW-1:0] out_data,
  input  logic                 out_ready,
  input  logic                 c_wr,
  input  logic [$clog2(N)-1:0] c_addr,
  input  logic signed [CW-1:0] c_data,
  input  logic                 c_commit
);
  localparam int AW  = $clog2(N);
  localparam int PW  = DW + CW;
  localparam int ACW = PW + AW;
  localparam int RW  = ACW + 1;
  localparam logic [CW-1:0] H0 = CW'(1) << SHIFT;
  localparam logic signed [RW-1:0] RND = (RW'(1) << SHIFT) >> 1;
  // x holds the N-1 older samples; in_data is the head of the window at the product stage
  logic signed [DW-1:0]  x [N-1];
  logic signed [DW-1:0]  nx [N];
  logic signed [CW-1:0]  hs [N];
  logic signed [CW-1:0]  hs_n [N];
  logic signed [CW-1:0]  ha [N];
  logic signed [PW-1:0]  p [N];
  logic signed [ACW-1:0] acc, sum;
  logic signed [OW-1:0]  res;
  logic                  v1, v2, adv, take;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;
  assign take     = in_valid && adv;
  always_comb begin
    nx[0] = in_data;
    for (int k = 1; k < N; k++) nx[k] = x[k-1];
    for (int k = 0; k < N; k++) hs_n[k] = (c_wr && c_addr == AW'(k)) ? c_data : hs[k];
    acc = '0;
    for (int k = 0; k < N; k++) acc += ACW'(p[k]);
  end
`ifdef PFIR_SAT_EN
  localparam logic signed [RW-1:0] MAXV = RW'({1'b0, {(OW-1){1'b1}}});
  localparam logic signed [RW-1:0] MINV = ~MAXV;
  logic signed [RW-1:0] sh;
  always_comb begin
    sh  = (RW'(sum) + RND) >>> SHIFT;
    res = sh > MAXV ? OW'(MAXV) : sh < MINV ? OW'(MINV) : OW'(sh);
  end
`else
  assign res = OW'((RW'(sum) + RND) >>> SHIFT);
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N - 1; k++) x[k] <= '0;
      for (int k = 0; k < N; k++) begin
        hs[k] <= k == 0 ? H0 : '0;
        ha[k] <= k == 0 ? H0 : '0;
        p[k]  <= '0;
      end
      v1        <= 1'b0;
      v2        <= 1'b0;
      sum       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      hs <= hs_n;
      if (c_commit) ha <= hs_n;
      if (take) for (int k = 0; k < N - 1; k++) x[k] <= nx[k];
      if (adv) begin
        v1 <= take;
        for (int k = 0; k < N; k++) p[k] <= PW'(nx[k]) * PW'(ha[k]);
        v2        <= v1;
        sum       <= acc;
        out_valid <= v2;
        if (v2) out_data <= res;
      end
    end
  end
endmodule

// File: tb/tb_pfir.sv
// tb_pfir: directed checks of pfir at N=4 with SHIFT=0 (u0) and SHIFT=1 (u1) sharing inputs.
module tb_pfir;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1, c_wr = 1'b0, c_commit = 1'b0;
  logic signed [15:0] in_data = '0, c_data = '0;
  logic [1:0] c_addr = '0;
  logic ir0, ov0, ir1, ov1;
  logic signed [15:0] od0, od1;
  int checks = 0, failures = 0;
  int q0[$], q1[$];

  pfir #(.N(4), .DW(16), .CW(16), .OW(16), .SHIFT(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_ready(out_ready),
    .c_wr(c_wr), .c_addr(c_addr), .c_data(c_data), .c_commit(c_commit));
  pfir #(.N(4), .DW(16), .CW(16), .OW(16), .SHIFT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_ready(out_ready),
    .c_wr(c_wr), .c_addr(c_addr), .c_data(c_data), .c_commit(c_commit));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && ov0 && out_ready) q0.push_back(int'(od0));
    if (!rst && ov1 && out_ready) q1.push_back(int'(od1));
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return i < q.size() ? q[i] : -99999;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; c_wr = 1'b0; c_commit = 1'b0; out_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    q0.delete(); q1.delete();
  endtask

  task automatic wr(input int a, input int d, input bit commit);
    c_wr = 1'b1; c_addr = 2'(a); c_data = 16'(d); c_commit = commit;
    step();
    c_wr = 1'b0; c_commit = 1'b0;
  endtask

  task automatic push(input int v);
    bit ok = 1'b0;
    in_valid = 1'b1; in_data = 16'(v);
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      ok = ir0;
      step();
    end
    in_valid = 1'b0;
    chk("push_acc", int'(ok), 1);
  endtask

  initial begin
    int e2[5] = '{1, 2, 3, 4, 0};
    int e3[5] = '{10, 20, 30, 40, 50};
    int e4[4];
    int e5[4] = '{3, -3, 2, -1};
`ifdef PFIR_SAT_EN
    e4 = '{32767, 32767, 32767, 32767};
`else
    e4 = '{1, 2, 3, 4};
`endif
    do_reset();
    chk("rst_ov", ov0, 0);
    chk("rst_od", od0, 0);
    chk("rst_ir", ir0, 1);
    // passthrough latency: output 3 advancing edges after each accept
    in_valid = 1'b1; in_data = 16'sd100; step();
    chk("t1_ov_e1", ov0, 0);
    in_data = 16'sd200; step();
    chk("t1_ov_e2", ov0, 0);
    in_data = -16'sd5; step();
    chk("t1_ov_e3", ov0, 1);
    chk("t1_od_100", od0, 100);
    in_valid = 1'b0; step();
    chk("t1_od_200", od0, 200);
    step();
    chk("t1_od_m5", od0, -5);
    step();
    chk("t1_ov_end", ov0, 0);

    // coefficient load, last write coincides with commit
    do_reset();
    wr(0, 1, 0); wr(1, 2, 0); wr(2, 3, 0); wr(3, 4, 1);
    push(1); push(0); push(0); push(0); push(0);
    repeat (5) step();
    chk("t2_n", q0.size(), 5);
    foreach (e2[i]) chk($sformatf("t2_y%0d", i), at(q0, i), e2[i]);

    // backpressure
    do_reset();
    out_ready = 1'b0;
    push(10); push(20); push(30);
    in_valid = 1'b1; in_data = 16'sd40; #1;
    chk("t3_ir_stall", ir0, 0);
    chk("t3_ov_stall", ov0, 1);
    chk("t3_od_stall", od0, 10);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t3_hold_ov%0d", i), ov0, 1);
      chk($sformatf("t3_hold_od%0d", i), od0, 10);
    end
    out_ready = 1'b1;
    push(40); push(50);
    repeat (6) step();
    chk("t3_n", q0.size(), 5);
    foreach (e3[i]) chk($sformatf("t3_y%0d", i), at(q0, i), e3[i]);

    // full-scale coefficients and input: wrap or saturate
    do_reset();
    for (int k = 0; k < 4; k++) wr(k, 32767, k == 3);
    for (int k = 0; k < 4; k++) push(32767);
    repeat (5) step();
    chk("t4_n", q0.size(), 4);
    foreach (e4[i]) chk($sformatf("t4_y%0d", i), at(q0, i), e4[i]);

    // SHIFT=1 rounding
    do_reset();
    push(3); push(-3);
    repeat (4) step();
    wr(0, 1, 1);
    push(3); push(-3);
    repeat (5) step();
    chk("t5_n", q1.size(), 4);
    foreach (e5[i]) chk($sformatf("t5_y%0d", i), at(q1, i), e5[i]);

    // reset with samples in flight
    do_reset();
    wr(0, 7, 1);
    push(1); push(2); push(3);
    chk("t6_ov_pre", ov0, 1);
    chk("t6_od_pre", od0, 7);
    #1 rst = 1'b1;
    #1;
    chk("t6_ov_async", ov0, 0);
    chk("t6_od_async", od0, 0);
    q0.delete();
    step();
    rst = 1'b0;
    chk("t6_ir", ir0, 1);
    repeat (5) step();
    chk("t6_no_out", q0.size(), 0);
    push(9);
    repeat (5) step();
    chk("t6_n", q0.size(), 1);
    chk("t6_pass", at(q0, 0), 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
